// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU core.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//   Holds the opcode values, the FSM state encoding and the legal-opcode check.
package acc_cpu_pkg;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_LOADI = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_ADDM  = 4'hB;
    localparam logic [3:0] OP_NOP   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    // Opcodes 0xC..0xE are unassigned; everything else is a defined operation.
    function automatic logic is_legal(input logic [3:0] opcode);
        return !((opcode == 4'hC) || (opcode == 4'hD) || (opcode == 4'hE));
    endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Accumulator ALU: computes the next accumulator value and carry for one opcode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, the core decides when to commit.
//   Ports: opcode, acc, operand (immediate or memory word), carry_in ->
//          result, carry_out, writes_acc (result should be committed to acc).
module acc_cpu_alu #(
    parameter int DATA_W = 4
) (
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              writes_acc
);
    import acc_cpu_pkg::*;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, operand};
    // Top bit of the widened difference is the unsigned borrow (operand > acc).
    assign diff = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        result     = acc;
        carry_out  = carry_in;
        writes_acc = 1'b1;
        case (opcode)
            OP_ADD, OP_ADDM: begin
                result    = sum[DATA_W-1:0];
                carry_out = sum[DATA_W];
            end
            OP_SUB: begin
                result    = diff[DATA_W-1:0];
                carry_out = diff[DATA_W];
            end
            OP_LOAD, OP_LOADI: result = operand;
            OP_AND:  result = acc & operand;
            OP_OR:   result = acc | operand;
            OP_XOR:  result = acc ^ operand;
            OP_NOT:  result = ~acc;
            OP_SHL: begin
                result    = {acc[DATA_W-2:0], 1'b0};
                carry_out = acc[DATA_W-1];
            end
            OP_SHR: begin
                result    = {1'b0, acc[DATA_W-1:1]};
                carry_out = acc[0];
            end
            // STORE, NOP and the unassigned opcodes leave acc and flags alone.
            default: writes_acc = 1'b0;
        endcase
    end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: one instruction at a time through IDLE -> READ -> EXEC.
// Latency: accept at edge N, results/done visible after edge N+2 (1 instr / 3 cycles).
// Backpressure: instr_ready is high only in IDLE; valid while not ready is ignored.
//   Ports: clk, rst_n; instr_valid/instr_ready/instr_opcode/instr_addr/instr_data in;
//          acc_out, flag_zero, flag_carry, done and illegal (one-cycle pulses) out.
module acc_cpu_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_opcode,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic [DATA_W-1:0] instr_data,
    output logic [DATA_W-1:0] acc_out,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              done,
    output logic              illegal
);
    import acc_cpu_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [3:0]        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] operand;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_writes;

    // Only LOAD and ADDM consume the memory word; everything else uses the immediate.
    assign operand = ((opcode_q == OP_LOAD) || (opcode_q == OP_ADDM)) ? mem_q : data_q;
    assign acc_out = acc;

    acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode     (opcode_q),
        .acc        (acc),
        .operand    (operand),
        .carry_in   (flag_carry),
        .result     (alu_result),
        .carry_out  (alu_carry),
        .writes_acc (alu_writes)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            opcode_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            mem_q       <= '0;
            acc         <= '0;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid && instr_ready) begin
                        opcode_q    <= instr_opcode;
                        addr_q      <= instr_addr;
                        data_q      <= instr_data;
                        instr_ready <= 1'b0;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    mem_q <= mem[addr_q];
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (opcode_q == OP_STORE) begin
                        mem[addr_q] <= acc;
                    end
                    if (alu_writes) begin
                        acc        <= alu_result;
                        flag_carry <= alu_carry;
                        flag_zero  <= (alu_result == '0);
                    end
                    illegal     <= !is_legal(opcode_q);
                    done        <= 1'b1;
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_cpu_core.sv
// Self-checking bench for acc_cpu_core at (DATA_W=4, ADDR_W=4) and (DATA_W=8, ADDR_W=5).
// Directed vector tables, hand-written multi-cycle sequences and random instructions
// checked against an arithmetic reference model of the instruction set.
module tb_acc_cpu_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus; sel picks which core sees instr_valid.
    logic       sel = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] op_r = '0;
    logic [4:0] addr_r = '0;
    logic [7:0] data_r = '0;

    logic       rdy4, z4, c4, done4, ill4;
    logic [3:0] acc4;
    logic       rdy8, z8, c8, done8, ill8;
    logic [7:0] acc8;

    acc_cpu_core #(.DATA_W(4), .ADDR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(valid && !sel), .instr_ready(rdy4),
        .instr_opcode(op_r), .instr_addr(addr_r[3:0]), .instr_data(data_r[3:0]),
        .acc_out(acc4), .flag_zero(z4), .flag_carry(c4), .done(done4), .illegal(ill4)
    );

    acc_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(valid && sel), .instr_ready(rdy8),
        .instr_opcode(op_r), .instr_addr(addr_r), .instr_data(data_r),
        .acc_out(acc8), .flag_zero(z8), .flag_carry(c8), .done(done8), .illegal(ill8)
    );

    int total = 0;
    int bad = 0;

    function automatic int cur_acc();  return sel ? int'(acc8) : int'(acc4); endfunction
    function automatic int cur_z();    return sel ? int'(z8) : int'(z4); endfunction
    function automatic int cur_c();    return sel ? int'(c8) : int'(c4); endfunction
    function automatic int cur_rdy();  return sel ? int'(rdy8) : int'(rdy4); endfunction
    function automatic int cur_done(); return sel ? int'(done8) : int'(done4); endfunction
    function automatic int cur_ill();  return sel ? int'(ill8) : int'(ill4); endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s (W=%0d): got %0d expected %0d", name, sel ? 8 : 4, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int w = 4;
    int aw = 4;
    int m_acc, m_z, m_c;
    int m_mem [32];

    function automatic void model_clear();
        m_acc = 0; m_z = 0; m_c = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 0;
    endfunction

    // Applies one instruction; returns 1 when the opcode is undefined.
    function automatic int model_step(input int op, input int a_in, input int d_in);
        int m = 1 << w;
        int a = a_in % (1 << aw);
        int d = d_in % m;
        int r = m_acc;
        int wr = 1;
        int ill = 0;
        case (op)
            0:  begin r = m_acc + d;        m_c = (r >= m) ? 1 : 0; r = r % m; end
            1:  begin m_c = (d > m_acc) ? 1 : 0; r = (m_acc - d + m) % m; end
            2:  begin m_mem[a] = m_acc; wr = 0; end
            3:  r = m_mem[a];
            4:  r = d;
            5:  r = m_acc & d;
            6:  r = m_acc | d;
            7:  r = m_acc ^ d;
            8:  r = (m - 1) - m_acc;
            9:  begin m_c = (m_acc >= m / 2) ? 1 : 0; r = (m_acc * 2) % m; end
            10: begin m_c = m_acc % 2; r = m_acc / 2; end
            11: begin r = m_acc + m_mem[a]; m_c = (r >= m) ? 1 : 0; r = r % m; end
            15: wr = 0;
            default: begin wr = 0; ill = 1; end
        endcase
        if (wr != 0) begin
            m_acc = r;
            m_z = (r == 0) ? 1 : 0;
        end
        return ill;
    endfunction

    // ---------------- drivers ----------------
    task automatic do_reset();
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_clear();
        check("rst_acc",   cur_acc(), 0);
        check("rst_zero",  cur_z(), 0);
        check("rst_carry", cur_c(), 0);
        check("rst_ready", cur_rdy(), 1);
        check("rst_done",  cur_done(), 0);
    endtask

    // Issues one instruction from a negedge and returns at the negedge of the done cycle.
    task automatic run_instr(input int op, input int a, input int d,
                             output int r_acc, output int r_z, output int r_c, output int r_ill);
        int n = 0;
        int e_ill;
        while (cur_rdy() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", cur_rdy(), 1);
        op_r = 4'(op); addr_r = 5'(a); data_r = 8'(d); valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept: the core must use its captured copy.
        valid = 1'b0;
        op_r = 4'($urandom); addr_r = 5'($urandom); data_r = 8'($urandom);
        @(negedge clk);
        check("ready_read", cur_rdy(), 0);
        check("done_read",  cur_done(), 0);
        @(negedge clk);
        check("ready_exec", cur_rdy(), 0);
        check("done_exec",  cur_done(), 0);
        @(negedge clk);
        e_ill = model_step(op, a, d);
        check("done_pulse", cur_done(), 1);
        check("illegal",    cur_ill(), e_ill);
        check("acc",        cur_acc(), m_acc);
        check("zero",       cur_z(), m_z);
        check("carry",      cur_c(), m_c);
        check("ready_back", cur_rdy(), 1);
        r_acc = cur_acc(); r_z = cur_z(); r_c = cur_c(); r_ill = cur_ill();
    endtask

    typedef struct {
        int op; int a; int d;
        int e_acc; int e_z; int e_c; int e_ill;
    } vec_t;

    vec_t tbl4 [$];
    vec_t tbl8 [$];

    task automatic run_table(input vec_t t [$], input string tag);
        int ra, rz, rc, ri;
        foreach (t[i]) begin
            run_instr(t[i].op, t[i].a, t[i].d, ra, rz, rc, ri);
            check({tag, "_acc"},   ra, t[i].e_acc);
            check({tag, "_zero"},  rz, t[i].e_z);
            check({tag, "_carry"}, rc, t[i].e_c);
            check({tag, "_ill"},   ri, t[i].e_ill);
        end
    endtask

    task automatic run_random(input int count);
        int ra, rz, rc, ri;
        for (int i = 0; i < count; i++) begin
            run_instr(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                      int'($urandom_range(0, 255)), ra, rz, rc, ri);
        end
    endtask

    initial begin
        int ra, rz, rc, ri;
        int accepts, last;

        //            op   a    d     acc  z  c  ill
        tbl4.push_back('{4, 0, 9,    9,   0, 0, 0});
        tbl4.push_back('{0, 0, 9,    2,   0, 1, 0});
        tbl4.push_back('{4, 0, 3,    3,   0, 1, 0});
        tbl4.push_back('{1, 0, 5,    14,  0, 1, 0});
        tbl4.push_back('{1, 0, 14,   0,   1, 0, 0});
        tbl4.push_back('{4, 0, 10,   10,  0, 0, 0});
        tbl4.push_back('{2, 5, 0,    10,  0, 0, 0});
        tbl4.push_back('{4, 0, 0,    0,   1, 0, 0});
        tbl4.push_back('{3, 5, 0,    10,  0, 0, 0});
        tbl4.push_back('{11, 5, 0,   4,   0, 1, 0});
        tbl4.push_back('{10, 0, 0,   2,   0, 0, 0});
        tbl4.push_back('{12, 3, 7,   2,   0, 0, 1});
        tbl4.push_back('{9, 0, 0,    4,   0, 0, 0});
        tbl4.push_back('{8, 0, 0,    11,  0, 0, 0});
        tbl4.push_back('{15, 0, 0,   11,  0, 0, 0});

        tbl8.push_back('{4, 0, 255,  255, 0, 0, 0});
        tbl8.push_back('{0, 0, 1,    0,   1, 1, 0});
        tbl8.push_back('{1, 0, 1,    255, 0, 1, 0});
        tbl8.push_back('{9, 0, 0,    254, 0, 1, 0});

        // ---------------- DATA_W=4, ADDR_W=4 ----------------
        sel = 1'b0; w = 4; aw = 4;
        do_reset();
        for (int a = 0; a < 16; a++) begin
            run_instr(3, a, 0, ra, rz, rc, ri);
            check("load_after_reset", ra, 0);
        end
        run_table(tbl4, "tbl4");

        // valid held for 12 cycles with changing data: only every third cycle accepts.
        accepts = 0;
        last = 0;
        for (int k = 0; k < 12; k++) begin
            op_r = 4'(4); addr_r = 5'($urandom); data_r = 8'($urandom); valid = 1'b1;
            check("hold_ready", cur_rdy(), (k % 3 == 0) ? 1 : 0);
            if (cur_rdy() != 0) begin
                accepts++;
                last = int'(data_r) % 16;
            end
            @(negedge clk);
        end
        valid = 1'b0;
        check("hold_accepts", accepts, 4);
        check("hold_acc", cur_acc(), last);
        check("hold_done", cur_done(), 1);
        m_acc = last;
        m_z = (last == 0) ? 1 : 0;

        run_random(150);

        // Reset while STORE 7 sits in EXEC: aborted, no done, memory stays clear.
        run_instr(4, 0, 5, ra, rz, rc, ri);
        op_r = 4'(2); addr_r = 5'(7); data_r = '0; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_exec", cur_rdy(), 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_done", cur_done(), 0);
        check("abort_acc", cur_acc(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_done_after", cur_done(), 0);
        check("abort_ready", cur_rdy(), 1);
        model_clear();
        run_instr(3, 7, 0, ra, rz, rc, ri);
        check("abort_mem7", ra, 0);

        // ---------------- DATA_W=8, ADDR_W=5 ----------------
        sel = 1'b1; w = 8; aw = 5;
        do_reset();
        for (int a = 0; a < 32; a++) begin
            run_instr(3, a, 0, ra, rz, rc, ri);
            check("load_after_reset8", ra, 0);
        end
        run_table(tbl8, "tbl8");
        run_random(150);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard ceiling so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule
